// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier peripheral:
// register offsets, CTRL/STATUS bit positions and FSM encoding.
package mul_seq_pkg;

  localparam logic [1:0] REG_OPA    = 2'd0;
  localparam logic [1:0] REG_OPB    = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic done);
    logic [31:0] w;
    w                = '0;
    w[STAT_BUSY_BIT] = busy;
    w[STAT_DONE_BIT] = done;
    return w;
  endfunction

endpackage

// File: rtl/mul_seq_periph_if.sv
// CPU look-ahead bus as seen by the multiplier peripheral, plus its
// registered hit/rdata return path into the system read mux.
interface mul_seq_periph_if;

  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic        hit;
  logic [31:0] rdata;

  modport master (
    output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    input  hit, rdata
  );

  modport slave (
    input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    output hit, rdata
  );

endinterface

// File: rtl/mul_seq_core.sv
// Unsigned radix-2 shift-add multiplier: operand latch, accumulator,
// step counter and IDLE/RUN/DONE control. Takes exactly N RUN cycles.
module mul_seq_core
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   opa,
  input  logic [N-1:0]   opb,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  mul_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   mcand;
  logic [N-1:0]    mplier;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   acc_sum;
  logic            load, step, finish, last_step;

  assign last_step = (cnt == CW'(N - 1));
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and control decode; a start during RUN is simply not accepted.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_step) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on start, one add/shift per RUN cycle, publish on the last.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else if (load) begin
      cnt    <= '0;
      mcand  <= W2'(opa);
      mplier <= opb;
      acc    <= '0;
    end else if (step) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (finish) result <= acc_sum;
    end
  end

endmodule

// File: rtl/mul_seq_periph.sv
// Memory-mapped sequential multiplier: 16-byte register window decoded from
// the CPU look-ahead bus, with registered hit/rdata for the read mux.
module mul_seq_periph
  import mul_seq_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFF0
) (
  input  logic             clk,
  input  logic             resetn,
  mul_seq_periph_if.slave  bus,
  output logic             busy,
  output logic             done
);

  logic           in_win;
  logic [1:0]     reg_sel;
  logic           wr_acc, rd_acc, start_req;
  logic [31:0]    wmask32;
  logic [N-1:0]   lane_mask;
  logic [N-1:0]   opa, opb;
  logic [2*N-1:0] result;
  logic [31:0]    rd_mux;
  logic           unused_bits;

  assign in_win    = (bus.mem_la_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = bus.mem_la_addr[3:2];
  assign wr_acc    = bus.mem_la_write && in_win;
  // A simultaneous write wins; the read is dropped.
  assign rd_acc    = bus.mem_la_read && !bus.mem_la_write && in_win;
  assign start_req = wr_acc && (reg_sel == REG_CTRL) && bus.mem_la_wdata[CTRL_START_BIT];

  assign wmask32   = {{8{bus.mem_la_wstrb[3]}}, {8{bus.mem_la_wstrb[2]}},
                      {8{bus.mem_la_wstrb[1]}}, {8{bus.mem_la_wstrb[0]}}};
  assign lane_mask = wmask32[N-1:0];

  assign unused_bits = ^{bus.mem_la_addr[1:0], bus.mem_la_wdata, wmask32};

  // Operand registers with byte-lane write enables.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opa <= '0;
      opb <= '0;
    end else if (wr_acc) begin
      if (reg_sel == REG_OPA)
        opa <= (opa & ~lane_mask) | (bus.mem_la_wdata[N-1:0] & lane_mask);
      if (reg_sel == REG_OPB)
        opb <= (opb & ~lane_mask) | (bus.mem_la_wdata[N-1:0] & lane_mask);
    end
  end

  mul_seq_core #(.N(N)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_req),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Read data selection; STATUS reflects the pre-edge busy/done.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_OPA:    rd_mux = 32'(opa);
      REG_OPB:    rd_mux = 32'(opb);
      REG_RESULT: rd_mux = 32'(result);
      REG_CTRL:   rd_mux = status_word(busy, done);
      default:    rd_mux = '0;
    endcase
  end

  // Registered read return; rdata holds its value on non-hitting cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.hit   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.hit <= rd_acc;
      if (rd_acc) bus.rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mul_seq_periph.sv
// Directed bench for mul_seq_periph with hand-computed expected values.
module tb_mul_seq_periph;

  localparam logic [31:0] BASE  = 32'h0FFF_FFF0;
  localparam logic [31:0] A_OPA = BASE + 32'h0;
  localparam logic [31:0] A_OPB = BASE + 32'h4;
  localparam logic [31:0] A_RES = BASE + 32'h8;
  localparam logic [31:0] A_CTL = BASE + 32'hC;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, done;

  int errors = 0;
  int checks = 0;

  mul_seq_periph_if bus ();

  mul_seq_periph #(.N(16), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    bus.mem_la_write = 1'b1;
    bus.mem_la_addr  = addr;
    bus.mem_la_wdata = data;
    bus.mem_la_wstrb = strb;
    @(posedge clk);
    #1;
    bus.mem_la_write = 1'b0;
    bus.mem_la_wstrb = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic h);
    @(negedge clk);
    bus.mem_la_read = 1'b1;
    bus.mem_la_addr = addr;
    @(posedge clk);
    #1;
    data = bus.rdata;
    h    = bus.hit;
    bus.mem_la_read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    bus_rd(addr, d, h);
    chk({tag, "_hit"}, 32'(h), 32'd1);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        h;
    int          n;
    int          cyc;

    bus.mem_la_read  = 1'b0;
    bus.mem_la_write = 1'b0;
    bus.mem_la_addr  = '0;
    bus.mem_la_wdata = '0;
    bus.mem_la_wstrb = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    resetn = 1'b1;
    rd_chk("rst_opa", A_OPA, 32'd0);
    rd_chk("rst_res", A_RES, 32'd0);
    rd_chk("rst_stat", A_CTL, 32'd0);

    // 3 * 5 with STATUS polling
    bus_wr(A_OPA, 32'd3, 4'hF);
    bus_wr(A_OPB, 32'd5, 4'hF);
    rd_chk("opa_rb", A_OPA, 32'd3);
    rd_chk("opb_rb", A_OPB, 32'd5);
    bus_wr(A_CTL, 32'd1, 4'hF);
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    bus_rd(A_CTL, d, h);
    while (d == 32'd1 && n < 40) begin
      n++;
      bus_rd(A_CTL, d, h);
    end
    chk("busy_polls", 32'(n), 32'd16);
    chk("stat_done", d, 32'd2);
    chk("done_port", 32'(done), 32'd1);
    rd_chk("res_3x5", A_RES, 32'h0000_000F);
    rd_chk("stat_sticky", A_CTL, 32'd2);

    // 0xFFFF * 0xFFFF, RESULT holds until completion, done cleared by start
    bus_wr(A_OPA, 32'h0000_FFFF, 4'hF);
    bus_wr(A_OPB, 32'h0000_FFFF, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    rd_chk("res_hold", A_RES, 32'h0000_000F);
    rd_chk("stat_run", A_CTL, 32'd1);
    wait_idle(cyc);
    rd_chk("res_ffff", A_RES, 32'hFFFE_0001);

    // Zero operand still takes full N cycles
    bus_wr(A_OPA, 32'd0, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    wait_idle(cyc);
    chk("zero_cycles", 32'(cyc), 32'd16);
    chk("zero_done", 32'(done), 32'd1);
    rd_chk("res_zero", A_RES, 32'd0);

    // Restart while busy is ignored; operand rewrite does not disturb the run
    bus_wr(A_OPA, 32'd6, 4'hF);
    bus_wr(A_OPB, 32'd7, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    repeat (3) @(posedge clk);
    bus_wr(A_OPA, 32'd7, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    wait_idle(cyc);
    chk("restart_cycles", 32'(cyc + 5), 32'd16);
    chk("restart_done", 32'(done), 32'd1);
    rd_chk("res_6x7", A_RES, 32'd42);
    rd_chk("opa_new", A_OPA, 32'd7);

    // Byte-lane writes
    bus_wr(A_OPA, 32'h0000_ABCD, 4'hF);
    bus_wr(A_OPA, 32'h0000_1234, 4'b0001);
    rd_chk("lane0", A_OPA, 32'h0000_AB34);
    bus_wr(A_OPA, 32'h0000_5600, 4'b0010);
    rd_chk("lane1", A_OPA, 32'h0000_5634);
    bus_wr(A_OPA, 32'hFFFF_0000, 4'b1100);
    rd_chk("lane23", A_OPA, 32'h0000_5634);

    // RESULT is read-only
    bus_wr(A_RES, 32'hDEAD_BEEF, 4'hF);
    rd_chk("res_ro", A_RES, 32'd42);

    // Simultaneous read and write: write wins, read dropped
    rd_chk("pre_rw", A_OPA, 32'h0000_5634);
    @(negedge clk);
    bus.mem_la_read  = 1'b1;
    bus.mem_la_write = 1'b1;
    bus.mem_la_addr  = A_OPB;
    bus.mem_la_wdata = 32'h0000_0022;
    bus.mem_la_wstrb = 4'hF;
    @(posedge clk);
    #1;
    chk("rw_hit", 32'(bus.hit), 32'd0);
    chk("rw_rdata", bus.rdata, 32'h0000_5634);
    bus.mem_la_read  = 1'b0;
    bus.mem_la_write = 1'b0;
    bus.mem_la_wstrb = 4'h0;
    rd_chk("rw_opb", A_OPB, 32'h0000_0022);

    // Accesses outside the window
    bus_rd(BASE + 32'h10, d, h);
    chk("oow_hit", 32'(h), 32'd0);
    chk("oow_rdata", d, 32'h0000_0022);
    bus_rd(BASE - 32'h4, d, h);
    chk("oow_lo_hit", 32'(h), 32'd0);
    chk("oow_lo_rdata", d, 32'h0000_0022);
    bus_wr(BASE + 32'h14, 32'h0000_0099, 4'hF);
    rd_chk("oow_wr", A_OPB, 32'h0000_0022);

    // Reset during RUN
    bus_wr(A_OPA, 32'd3, 4'hF);
    bus_wr(A_OPB, 32'd5, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    repeat (8) @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hit", 32'(bus.hit), 32'd0);
    chk("arst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd_chk("arst_res", A_RES, 32'd0);
    rd_chk("arst_opa", A_OPA, 32'd0);
    rd_chk("arst_stat", A_CTL, 32'd0);
    bus_wr(A_OPA, 32'd9, 4'hF);
    bus_wr(A_OPB, 32'd11, 4'hF);
    bus_wr(A_CTL, 32'd1, 4'hF);
    wait_idle(cyc);
    chk("post_cycles", 32'(cyc), 32'd16);
    rd_chk("res_9x11", A_RES, 32'd99);
    rd_chk("post_stat", A_CTL, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq_periph.md
MUL_SEQ_PERIPH -- requirements
Module: mul_seq_periph

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0FFF_FFF0, 16-byte aligned register window base.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mem_la_read, input, 1, CPU look-ahead read strobe.
REQ-006 SHALL have port mem_la_write, input, 1, CPU look-ahead write strobe.
REQ-007 SHALL have port mem_la_addr, input, 32, look-ahead byte address.
REQ-008 SHALL have port mem_la_wdata, input, 32, look-ahead write data.
REQ-009 SHALL have port mem_la_wstrb, input, 4, byte-lane write enables.
REQ-010 SHALL have port hit, output, 1, registered: previous-cycle access decoded into the window.
REQ-011 SHALL have port rdata, output, 32, registered read data.
REQ-012 SHALL have port busy, output, 1, multiplication in progress.
REQ-013 SHALL have port done, output, 1, sticky result-valid flag.

Function
REQ-014 SHALL decode a window access when mem_la_addr[31:4]==BASE_ADDR[31:4]; mem_la_addr[3:2] selects register; mem_la_addr[1:0] ignored.
REQ-015 SHALL map offsets: 0x0 OPA (RW, bits N-1:0), 0x4 OPB (RW, bits N-1:0), 0x8 RESULT (RO, 2N bits), 0xC CTRL/STATUS (write bit0=start; read bit0=busy, bit1=done).
REQ-016 SHALL update OPA/OPB only in lanes with mem_la_wstrb set; lanes 2-3 ignored; unused read bits return 0.
REQ-017 SHALL ignore writes to RESULT and accesses outside the window (hit=0, rdata unchanged).
REQ-018 SHALL register rdata and hit on the edge sampling mem_la_read, so data is valid one cycle after the strobe.
REQ-019 SHALL implement FSM IDLE -> RUN on write of CTRL bit0=1 while not busy; RUN -> DONE after exactly N RUN cycles; DONE -> RUN on next start.
REQ-020 SHALL latch OPA/OPB into internal operand copies at the start edge; later OPA/OPB writes do not affect the running product.
REQ-021 SHALL compute unsigned radix-2 shift-add: each RUN cycle adds the shifted multiplicand when the current multiplier LSB is 1, then shifts; accumulator 2N bits, no overflow possible.
REQ-022 SHALL assert busy from the edge after start until the edge completing cycle N; done rises on that same edge; start-to-done latency = N+1 edges.
REQ-023 SHALL ignore a start write while busy (no restart, no error).
REQ-024 SHALL clear done on an accepted start; reading RESULT or STATUS does not clear done.
REQ-025 SHALL hold RESULT at the previous product until the new product completes; RESULT updates only at completion.
REQ-026 SHALL take N cycles even when an operand is zero.
REQ-027 SHALL give write priority if mem_la_read and mem_la_write assert together; the read is dropped.
REQ-028 SHALL return current busy/done in STATUS read on the completion edge as the pre-edge values.

Reset
REQ-029 SHALL on resetn=0, asynchronously, force FSM IDLE and OPA, OPB, internal operands, accumulator, RESULT, rdata, hit, busy, done to 0.
REQ-030 SHALL abort an in-flight multiplication on reset with no partial result retained; first start after release behaves as from power-up.

Structure
REQ-031 SHALL place register offsets, CTRL/STATUS bit positions and FSM state encoding in shared package mul_seq_pkg.
REQ-032 SHALL contain one sub-module mul_seq_core (operand latch, accumulator, counter, FSM); the bus decode/register file remains in mul_seq_periph.
REQ-033 SHALL plug into the system memory-read mux via hit/rdata, without changing CPU bus timing.

Verification
REQ-034 SHALL cover write OPA=3, OPB=5, start; poll STATUS -> busy=1 for 16 cycles, then done=1; RESULT=0x0000000F.
REQ-035 SHALL cover OPA=0xFFFF, OPB=0xFFFF -> RESULT=0xFFFE0001; OPA=0 -> RESULT=0 after full 16 cycles.
REQ-036 SHALL cover start, rewrite OPA=7 and start again at cycle 5 -> ignored; RESULT uses original operands; done at cycle 17.
REQ-037 SHALL cover write OPA with wstrb=4'b0001, wdata=0x1234 on top of 0xABCD -> OPA reads 0xAB34.
REQ-038 SHALL cover resetn low at RUN cycle 8 -> busy=0, done=0, RESULT=0 immediately; new start yields correct product.
REQ-039 SHALL cover read at BASE_ADDR+0x10 -> hit=0 and rdata unchanged.
